// File: rtl/serial_incrementer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_incrementer_ctrl_pkg
// Purpose  : State encoding shared by the bit-serial incrementer controller.
// Revision : 1.0 - initial release
// ============================================================================
package serial_incrementer_ctrl_pkg;

    // 2'b11 is unused and is treated as IDLE by the controller.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

endpackage : serial_incrementer_ctrl_pkg
`default_nettype wire

// File: rtl/b2_halfadder_p.sv
`default_nettype none
// ============================================================================
// Module   : b2_halfadder_p
// Purpose  : Gate-level base-2 half adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module b2_halfadder_p (
    input  logic i_x,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_x ^ i_cin;
    assign o_cout = i_x & i_cin;

endmodule : b2_halfadder_p
`default_nettype wire

// File: rtl/serial_incrementer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_incrementer_ctrl
// Purpose  : Computes X + CIN one bit per cycle through a single half adder,
//            with a soc/eoc start/end-of-conversion handshake.
// Revision : 1.0 - initial release
// ============================================================================
module serial_incrementer_ctrl
    import serial_incrementer_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         soc,
    input  logic [N-1:0] x,
    input  logic         cin,
    output logic         eoc,
    output logic [N-1:0] s,
    output logic         cout
);

    localparam int CW = $clog2(N + 1);

    state_t         r_state;
    logic [N-1:0]   r_x_sr;
    logic [N-1:0]   r_s_sr;
    logic           r_carry;
    logic [CW-1:0]  r_cnt;
    logic           r_eoc;
    logic [N-1:0]   r_s;
    logic           r_cout;

    logic           w_ha_s;
    logic           w_ha_cout;
    logic [N-1:0]   w_s_next;

    b2_halfadder_p u_ha (
        .i_x    (r_x_sr[0]),
        .i_cin  (r_carry),
        .o_s    (w_ha_s),
        .o_cout (w_ha_cout)
    );

    // Sum bits enter at the MSB so the LSB-first result lands in place after N shifts.
    generate
        if (N == 1) begin : g_single
            assign w_s_next = w_ha_s;
        end else begin : g_multi
            assign w_s_next = {w_ha_s, r_s_sr[N-1:1]};
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_state <= IDLE;
            r_x_sr  <= '0;
            r_s_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_eoc   <= 1'b1;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (soc) begin
                        r_x_sr  <= x;
                        r_carry <= cin;
                        r_cnt   <= CW'(N);
                        r_s_sr  <= '0;
                        r_eoc   <= 1'b0;
                        r_state <= RUN;
                    end else begin
                        r_eoc   <= 1'b1;
                    end
                end
                RUN: begin
                    r_s_sr  <= w_s_next;
                    r_x_sr  <= r_x_sr >> 1;
                    r_carry <= w_ha_cout;
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_s     <= w_s_next;
                        r_cout  <= w_ha_cout;
                        r_eoc   <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    // A held soc must drop before another conversion can start.
                    r_eoc <= 1'b1;
                    if (!soc) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_eoc   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign eoc  = r_eoc;
    assign s    = r_s;
    assign cout = r_cout;

endmodule : serial_incrementer_ctrl
`default_nettype wire

// File: tb/tb_serial_incrementer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_incrementer_ctrl
// Purpose  : Directed self-checking bench for N=8 and N=1 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_incrementer_ctrl;

    logic       clock;
    logic       reset_;
    logic       soc8, soc1;
    logic [7:0] x8;
    logic [0:0] x1;
    logic       cin8, cin1;
    logic       eoc8, eoc1;
    logic [7:0] s8;
    logic [0:0] s1;
    logic       cout8, cout1;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] x;
        logic       cin;
        logic [7:0] exp_s;
        logic       exp_cout;
    } vec_t;

    vec_t vecs [8];

    serial_incrementer_ctrl #(.N(8)) u_dut8 (
        .clock  (clock),
        .reset_ (reset_),
        .soc    (soc8),
        .x      (x8),
        .cin    (cin8),
        .eoc    (eoc8),
        .s      (s8),
        .cout   (cout8)
    );

    serial_incrementer_ctrl #(.N(1)) u_dut1 (
        .clock  (clock),
        .reset_ (reset_),
        .soc    (soc1),
        .x      (x1),
        .cin    (cin1),
        .eoc    (eoc1),
        .s      (s1),
        .cout   (cout1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulses soc for one edge on the N=8 instance and measures how long eoc stays low.
    task automatic op8(input string name, input logic [7:0] xv, input logic cv,
                       input logic [7:0] es, input logic ec);
        int lows;
        @(negedge clock);
        soc8 = 1'b1; x8 = xv; cin8 = cv;
        @(negedge clock);
        soc8 = 1'b0;
        lows = 0;
        while (eoc8 == 1'b0 && lows < 24) begin
            lows++;
            @(negedge clock);
        end
        check({name, "_cycles"}, lows, 8);
        check({name, "_s"}, s8, es);
        check({name, "_cout"}, cout8, ec);
    endtask

    task automatic op1(input string name, input logic xv, input logic cv,
                       input logic es, input logic ec);
        int lows;
        @(negedge clock);
        soc1 = 1'b1; x1 = xv; cin1 = cv;
        @(negedge clock);
        soc1 = 1'b0;
        lows = 0;
        while (eoc1 == 1'b0 && lows < 8) begin
            lows++;
            @(negedge clock);
        end
        check({name, "_cycles"}, lows, 1);
        check({name, "_s"}, s1, es);
        check({name, "_cout"}, cout1, ec);
    endtask

    initial begin
        int lows;
        checks = 0;
        errors = 0;
        reset_ = 1'b0;
        soc8 = 1'b0; x8 = '0; cin8 = 1'b0;
        soc1 = 1'b0; x1 = '0; cin1 = 1'b0;

        vecs[0] = '{8'h05, 1'b1, 8'h06, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h7F, 1'b1, 8'h80, 1'b0};
        vecs[6] = '{8'hFE, 1'b1, 8'hFF, 1'b0};
        vecs[7] = '{8'hFF, 1'b0, 8'hFF, 1'b0};

        repeat (2) @(negedge clock);
        check("rst_eoc8", eoc8, 1);
        check("rst_s8", s8, 0);
        check("rst_cout8", cout8, 0);
        check("rst_eoc1", eoc1, 1);
        reset_ = 1'b1;
        @(negedge clock);
        check("idle_eoc8", eoc8, 1);

        for (int i = 0; i < 8; i++) begin
            op8($sformatf("vec%0d", i), vecs[i].x, vecs[i].cin, vecs[i].exp_s, vecs[i].exp_cout);
        end

        // soc held high: exactly one conversion, then parked in HOLD.
        @(negedge clock);
        soc8 = 1'b1; x8 = 8'h0F; cin8 = 1'b1;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (eoc8 == 1'b0) lows++;
        end
        check("held_lows", lows, 8);
        check("held_s", s8, 8'h10);
        check("held_cout", cout8, 0);
        soc8 = 1'b0;
        @(negedge clock);
        check("held_release_eoc", eoc8, 1);
        @(negedge clock);
        check("held_idle_eoc", eoc8, 1);

        // Operand and cin changed during RUN must have no effect.
        @(negedge clock);
        soc8 = 1'b1; x8 = 8'h3F; cin8 = 1'b1;
        @(negedge clock);
        soc8 = 1'b0;
        @(negedge clock);
        x8 = 8'h00; cin8 = 1'b0;
        lows = 0;
        while (eoc8 == 1'b0 && lows < 24) begin
            lows++;
            @(negedge clock);
        end
        check("midrun_lows", lows, 7);
        check("midrun_s", s8, 8'h40);
        check("midrun_cout", cout8, 0);

        // Asynchronous reset in the middle of a conversion.
        op8("prerst", 8'h05, 1'b1, 8'h06, 1'b0);
        @(negedge clock);
        soc8 = 1'b1; x8 = 8'hFF; cin8 = 1'b1;
        @(negedge clock);
        soc8 = 1'b0;
        repeat (3) @(negedge clock);
        check("prerst_busy", eoc8, 0);
        reset_ = 1'b0;
        #1;
        check("arst_eoc", eoc8, 1);
        check("arst_s", s8, 0);
        check("arst_cout", cout8, 0);
        @(negedge clock);
        reset_ = 1'b1;
        op8("postrst", 8'h01, 1'b1, 8'h02, 1'b0);

        op1("n1_a", 1'b1, 1'b1, 1'b0, 1'b1);
        op1("n1_b", 1'b0, 1'b1, 1'b1, 1'b0);
        op1("n1_c", 1'b1, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_serial_incrementer_ctrl
`default_nettype wire
